// File: rtl/pa_sysmap_cfg.sv
// Sysmap region configuration block: eight base/flag register pairs with
// lock bits, behind a two-cycle request/ack register interface.
module pa_sysmap_cfg #(
  parameter int         ENTRY_NUM = 8,
  parameter logic [4:0] FLG_RST   = 5'b10011
) (
  input  logic        cpuclk,
  input  logic        cpurst,
  input  logic        cfg_req,
  input  logic        cfg_wr,
  input  logic [5:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic        cfg_ack,
  output logic        cfg_err,
  output logic [31:0] cfg_rdata,
  output logic [19:0] sysmap_base_addr0_value,
  output logic [19:0] sysmap_base_addr1_value,
  output logic [19:0] sysmap_base_addr2_value,
  output logic [19:0] sysmap_base_addr3_value,
  output logic [19:0] sysmap_base_addr4_value,
  output logic [19:0] sysmap_base_addr5_value,
  output logic [19:0] sysmap_base_addr6_value,
  output logic [19:0] sysmap_base_addr7_value,
  output logic [4:0]  sysmap_flg0_value,
  output logic [4:0]  sysmap_flg1_value,
  output logic [4:0]  sysmap_flg2_value,
  output logic [4:0]  sysmap_flg3_value,
  output logic [4:0]  sysmap_flg4_value,
  output logic [4:0]  sysmap_flg5_value,
  output logic [4:0]  sysmap_flg6_value,
  output logic [4:0]  sysmap_flg7_value,
  output logic        sysmap_cfg_upd
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [19:0] base_q [ENTRY_NUM];
  logic [4:0]  flg_q  [ENTRY_NUM];
  logic [ENTRY_NUM-1:0] lock_q;

  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        upd_q, upd_d;
  logic [3:0]  raddr_q, raddr_d;

  logic        sample;
  logic [2:0]  ent;
  logic        is_flg;
  logic [19:0] wbase;
  logic [19:0] lo_bound;
  logic [19:0] hi_bound;
  logic        range_ok;
  logic        wr_ok;
  logic        base_we;
  logic        flg_we;
  logic [2:0]  rent;
  logic [31:0] rmux;
  logic        unused;

  assign ent    = cfg_addr[5:3];
  assign is_flg = cfg_addr[2];
  assign wbase  = cfg_wdata[31:12];
  assign unused = ^{cfg_addr[1:0], cfg_wdata[11:8], cfg_wdata[6:5]};

  always_comb begin
    state_d = state_q;
    sample  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_req) begin
          state_d = ACK;
          sample  = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bases must stay monotonic: an entry may not cross either neighbour.
  always_comb begin
    lo_bound = 20'h00000;
    hi_bound = 20'hFFFFF;
    if (ent != 3'd0) lo_bound = base_q[ent - 3'd1];
    if (ent != 3'd7) hi_bound = base_q[ent + 3'd1];
  end

  assign range_ok = (wbase >= lo_bound) && (wbase <= hi_bound);
  assign wr_ok    = cfg_wr && !lock_q[ent] && (is_flg || range_ok);
  assign base_we  = sample && wr_ok && !is_flg;
  assign flg_we   = sample && wr_ok && is_flg;

  always_comb begin
    ack_d   = sample;
    err_d   = sample && cfg_wr && !wr_ok;
    upd_d   = sample && wr_ok;
    raddr_d = raddr_q;
    if (sample) raddr_d = cfg_addr[5:2];
  end

  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      upd_q   <= 1'b0;
      raddr_q <= 4'h0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      upd_q   <= upd_d;
      raddr_q <= raddr_d;
    end
  end

  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        base_q[i] <= 20'hFFFFF;
        flg_q[i]  <= FLG_RST;
      end
      lock_q <= '0;
    end else begin
      if (base_we) base_q[ent] <= wbase;
      if (flg_we) begin
        flg_q[ent] <= cfg_wdata[4:0];
        if (cfg_wdata[7]) lock_q[ent] <= 1'b1;
      end
    end
  end

  assign rent = raddr_q[3:1];

  always_comb begin
    rmux = {base_q[rent], 12'h000};
    if (raddr_q[0]) rmux = {24'h0, lock_q[rent], 2'b00, flg_q[rent]};
  end

  assign cfg_ack        = ack_q;
  assign cfg_err        = err_q;
  assign sysmap_cfg_upd = upd_q;
  assign cfg_rdata      = ack_q ? rmux : 32'h0;

  assign sysmap_base_addr0_value = base_q[0];
  assign sysmap_base_addr1_value = base_q[1];
  assign sysmap_base_addr2_value = base_q[2];
  assign sysmap_base_addr3_value = base_q[3];
  assign sysmap_base_addr4_value = base_q[4];
  assign sysmap_base_addr5_value = base_q[5];
  assign sysmap_base_addr6_value = base_q[6];
  assign sysmap_base_addr7_value = base_q[7];

  assign sysmap_flg0_value = flg_q[0];
  assign sysmap_flg1_value = flg_q[1];
  assign sysmap_flg2_value = flg_q[2];
  assign sysmap_flg3_value = flg_q[3];
  assign sysmap_flg4_value = flg_q[4];
  assign sysmap_flg5_value = flg_q[5];
  assign sysmap_flg6_value = flg_q[6];
  assign sysmap_flg7_value = flg_q[7];

endmodule

// File: tb/tb_pa_sysmap_cfg.sv
// Directed bench for pa_sysmap_cfg: reset, reads, writes, ordering,
// locking, held requests and reset during an ack cycle.
module tb_pa_sysmap_cfg;

  logic        cpuclk;
  logic        cpurst;
  logic        cfg_req;
  logic        cfg_wr;
  logic [5:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_ack;
  logic        cfg_err;
  logic [31:0] cfg_rdata;
  logic [19:0] base_o [8];
  logic [4:0]  flg_o  [8];
  logic        upd;

  int tests;
  int failed;
  int lat;
  int acks;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_upd;
  logic [5:0]  mask;

  pa_sysmap_cfg dut (
    .cpuclk                  (cpuclk),
    .cpurst                  (cpurst),
    .cfg_req                 (cfg_req),
    .cfg_wr                  (cfg_wr),
    .cfg_addr                (cfg_addr),
    .cfg_wdata               (cfg_wdata),
    .cfg_ack                 (cfg_ack),
    .cfg_err                 (cfg_err),
    .cfg_rdata               (cfg_rdata),
    .sysmap_base_addr0_value (base_o[0]),
    .sysmap_base_addr1_value (base_o[1]),
    .sysmap_base_addr2_value (base_o[2]),
    .sysmap_base_addr3_value (base_o[3]),
    .sysmap_base_addr4_value (base_o[4]),
    .sysmap_base_addr5_value (base_o[5]),
    .sysmap_base_addr6_value (base_o[6]),
    .sysmap_base_addr7_value (base_o[7]),
    .sysmap_flg0_value       (flg_o[0]),
    .sysmap_flg1_value       (flg_o[1]),
    .sysmap_flg2_value       (flg_o[2]),
    .sysmap_flg3_value       (flg_o[3]),
    .sysmap_flg4_value       (flg_o[4]),
    .sysmap_flg5_value       (flg_o[5]),
    .sysmap_flg6_value       (flg_o[6]),
    .sysmap_flg7_value       (flg_o[7]),
    .sysmap_cfg_upd          (upd)
  );

  initial cpuclk = 1'b0;
  always #5 cpuclk = ~cpuclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic wr, input logic [5:0] a,
                        input logic [31:0] d);
    @(negedge cpuclk);
    cfg_req   = 1'b1;
    cfg_wr    = wr;
    cfg_addr  = a;
    cfg_wdata = d;
    lat       = -1;
    r_rdata   = 32'hDEAD_BEEF;
    r_err     = 1'bx;
    r_upd     = 1'bx;
    for (int i = 0; i < 4; i++) begin
      @(negedge cpuclk);
      if (cfg_ack === 1'b1) begin
        lat     = i;
        r_rdata = cfg_rdata;
        r_err   = cfg_err;
        r_upd   = upd;
        break;
      end
    end
    cfg_req = 1'b0;
    cfg_wr  = 1'b0;
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    cpurst    = 1'b1;
    cfg_req   = 1'b0;
    cfg_wr    = 1'b0;
    cfg_addr  = 6'h0;
    cfg_wdata = 32'h0;
    repeat (3) @(negedge cpuclk);

    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rst_base%0d", i), {12'h0, base_o[i]}, 32'h000F_FFFF);
      chk($sformatf("rst_flg%0d", i), {27'h0, flg_o[i]}, 32'h13);
    end
    chk("rst_ack", {31'h0, cfg_ack}, 32'h0);
    chk("rst_err", {31'h0, cfg_err}, 32'h0);
    chk("rst_upd", {31'h0, upd}, 32'h0);
    chk("rst_rdata", cfg_rdata, 32'h0);
    cpurst = 1'b0;

    // read reset flag of entry 0
    access(1'b0, 6'h04, 32'h0);
    chk("rd_flg0_lat", lat, 0);
    chk("rd_flg0_data", r_rdata, 32'h0000_0013);
    chk("rd_flg0_err", {31'h0, r_err}, 32'h0);
    chk("rd_flg0_upd", {31'h0, r_upd}, 32'h0);
    @(negedge cpuclk);
    chk("rdata_gated", cfg_rdata, 32'h0);

    access(1'b1, 6'h00, 32'h0000_0000);
    chk("wr_b0_lat", lat, 0);
    chk("wr_b0_err", {31'h0, r_err}, 32'h0);
    chk("wr_b0_upd", {31'h0, r_upd}, 32'h1);
    chk("wr_b0_val", {12'h0, base_o[0]}, 32'h0);
    access(1'b1, 6'h08, 32'h2000_0000);
    chk("wr_b1_err", {31'h0, r_err}, 32'h0);
    chk("wr_b1_upd", {31'h0, r_upd}, 32'h1);
    chk("wr_b1_val", {12'h0, base_o[1]}, 32'h0002_0000);

    access(1'b1, 6'h08, 32'h0000_0000);
    chk("wr_b1_eq_err", {31'h0, r_err}, 32'h0);
    chk("wr_b1_eq_val", {12'h0, base_o[1]}, 32'h0);
    access(1'b1, 6'h08, 32'h2000_0000);
    chk("wr_b1_re_val", {12'h0, base_o[1]}, 32'h0002_0000);
    access(1'b1, 6'h10, 32'h1000_0000);
    chk("wr_b2_lo_err", {31'h0, r_err}, 32'h1);
    chk("wr_b2_lo_upd", {31'h0, r_upd}, 32'h0);
    chk("wr_b2_lo_val", {12'h0, base_o[2]}, 32'h000F_FFFF);
    access(1'b1, 6'h10, 32'h2000_0000);
    chk("wr_b2_eq_err", {31'h0, r_err}, 32'h0);
    chk("wr_b2_eq_val", {12'h0, base_o[2]}, 32'h0002_0000);
    access(1'b1, 6'h38, 32'h1000_0000);
    chk("wr_b7_lo_err", {31'h0, r_err}, 32'h1);
    chk("wr_b7_lo_val", {12'h0, base_o[7]}, 32'h000F_FFFF);
    access(1'b1, 6'h30, 32'hFFFF_F000);
    chk("wr_b6_top_err", {31'h0, r_err}, 32'h0);
    chk("wr_b6_top_val", {12'h0, base_o[6]}, 32'h000F_FFFF);
    access(1'b1, 6'h08, 32'h3000_0000);
    chk("wr_b1_hi_err", {31'h0, r_err}, 32'h1);
    chk("wr_b1_hi_val", {12'h0, base_o[1]}, 32'h0002_0000);

    // lock entry 1
    access(1'b1, 6'h0C, 32'h0000_0085);
    chk("wr_f1_err", {31'h0, r_err}, 32'h0);
    chk("wr_f1_upd", {31'h0, r_upd}, 32'h1);
    chk("wr_f1_val", {27'h0, flg_o[1]}, 32'h05);
    access(1'b1, 6'h08, 32'h1000_0000);
    chk("lk_b1_err", {31'h0, r_err}, 32'h1);
    chk("lk_b1_upd", {31'h0, r_upd}, 32'h0);
    chk("lk_b1_val", {12'h0, base_o[1]}, 32'h0002_0000);
    access(1'b1, 6'h0C, 32'h0000_001F);
    chk("lk_f1_err", {31'h0, r_err}, 32'h1);
    chk("lk_f1_val", {27'h0, flg_o[1]}, 32'h05);
    access(1'b0, 6'h0C, 32'h0);
    chk("rd_f1_data", r_rdata, 32'h0000_0085);
    chk("rd_f1_err", {31'h0, r_err}, 32'h0);
    access(1'b0, 6'h0B, 32'h0);
    chk("rd_b1_data", r_rdata, 32'h2000_0000);

    // held request: acks on alternate cycles
    @(negedge cpuclk);
    cfg_req  = 1'b1;
    cfg_wr   = 1'b0;
    cfg_addr = 6'h04;
    acks     = 0;
    mask     = 6'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge cpuclk);
      mask[i] = cfg_ack;
      if (cfg_ack === 1'b1) acks++;
    end
    cfg_req = 1'b0;
    chk("held_acks", acks, 3);
    chk("held_mask", {26'h0, mask}, 32'h15);

    // reset during the ack cycle of a legal write
    @(negedge cpuclk);
    @(negedge cpuclk);
    cfg_req   = 1'b1;
    cfg_wr    = 1'b1;
    cfg_addr  = 6'h18;
    cfg_wdata = 32'h3000_0000;
    @(posedge cpuclk);
    #1;
    chk("pre_rst_ack", {31'h0, cfg_ack}, 32'h1);
    cpurst = 1'b1;
    #1;
    chk("arst_ack", {31'h0, cfg_ack}, 32'h0);
    chk("arst_upd", {31'h0, upd}, 32'h0);
    chk("arst_rdata", cfg_rdata, 32'h0);
    chk("arst_b1", {12'h0, base_o[1]}, 32'h000F_FFFF);
    chk("arst_b3", {12'h0, base_o[3]}, 32'h000F_FFFF);
    chk("arst_f1", {27'h0, flg_o[1]}, 32'h13);
    cfg_req = 1'b0;
    cfg_wr  = 1'b0;
    repeat (2) @(negedge cpuclk);
    chk("rst_hold_ack", {31'h0, cfg_ack}, 32'h0);
    cpurst = 1'b0;

    // lock cleared by reset
    access(1'b1, 6'h0C, 32'h0000_0002);
    chk("post_f1_err", {31'h0, r_err}, 32'h0);
    chk("post_f1_val", {27'h0, flg_o[1]}, 32'h02);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pa_sysmap_cfg.md
PA_SYSMAP_CFG -- requirements
Module: pa_sysmap_cfg

Interface
REQ-001 The block SHALL have parameter ENTRY_NUM, default 8, meaning the number of sysmap regions; only 8 is supported.
REQ-002 The block SHALL have parameter FLG_RST, default 5'b10011, meaning the reset value of every flag field.
REQ-003 cpuclk  input  1  the single clock; all state SHALL be on its rising edge.
REQ-004 cpurst  input  1  reset, asynchronous and active-high.
REQ-005 cfg_req  input  1  access request; held until cfg_ack.
REQ-006 cfg_wr  input  1  1 = write, 0 = read; valid with cfg_req.
REQ-007 cfg_addr  input  6  byte offset; [5:3] = entry, [2] = 0 base / 1 flag, [1:0] ignored.
REQ-008 cfg_wdata  input  32  write data; valid with cfg_req.
REQ-009 cfg_ack  output  1  one-cycle completion pulse.
REQ-010 cfg_err  output  1  error status, valid with cfg_ack.
REQ-011 cfg_rdata  output  32  read data, valid with cfg_ack, 0 otherwise.
REQ-012 sysmap_base_addr0_value..sysmap_base_addr7_value  output  20 each  region upper bound, PA[31:12] granularity.
REQ-013 sysmap_flg0_value..sysmap_flg7_value  output  5 each  region attribute flags.
REQ-014 sysmap_cfg_upd  output  1  one-cycle pulse after any successful write.

Function
REQ-015 The FSM SHALL have states IDLE and ACK; IDLE->ACK on cfg_req; ACK->IDLE unconditionally.
REQ-016 The request SHALL be sampled in IDLE; cfg_ack SHALL assert exactly 1 cycle after sampling, and a request still high in ACK SHALL NOT be resampled.
REQ-017 Throughput SHALL be at most one access per 2 cycles; back-to-back requests SHALL each get their own ack.
REQ-018 A base write SHALL load cfg_wdata[31:12] into the entry's base register, with the update visible on the output in the cycle cfg_ack is high.
REQ-019 A flag write SHALL load cfg_wdata[4:0] into the flag register; if cfg_wdata[7]=1 it SHALL also set the entry lock bit.
REQ-020 A write to a locked entry, base or flag, SHALL be discarded with cfg_err=1; the lock SHALL clear only on reset.
REQ-021 A base write whose value is below the base of entry-1 (entry>0) or above the base of entry+1 (entry<7) SHALL be discarded with cfg_err=1; an equal value SHALL be legal.
REQ-022 Reads SHALL return {base,12'h0} for a base read and {24'h0,lock,2'b0,flg} for a flag read, and SHALL never produce an error.
REQ-023 sysmap_cfg_upd SHALL pulse in the cycle cfg_ack is high, for successful writes only.
REQ-024 All outputs SHALL be driven from flops except cfg_rdata, which is muxed from flops and gated by cfg_ack.

Reset
REQ-025 On cpurst high, asynchronously: every base = 20'hFFFFF, every flag = FLG_RST, every lock = 0, FSM = IDLE, and cfg_ack, cfg_err and sysmap_cfg_upd = 0.
REQ-026 Reset asserted while in ACK SHALL abort the access with no ack and no register change, and the state SHALL remain at reset values until reset is released.
REQ-027 The first request SHALL be sampled no earlier than the first rising edge after reset deassertion.

Verification
REQ-028 Reset, then read offset 0x04 -> cfg_ack 1 cycle later, cfg_rdata=32'h00000013, cfg_err=0.
REQ-029 From reset, write 0x00 data 32'h0000_0000, then 0x08 data 32'h2000_0000 -> both succeed, sysmap_base_addr0_value=20'h00000, sysmap_base_addr1_value=20'h20000, and sysmap_cfg_upd pulses twice.
REQ-030 Continuing from REQ-029, write 0x08 data 32'h0000_0000 is legal; then write 0x10 data 32'h1000_0000 with base1=20'h20000 -> cfg_err=1, base2 stays 20'hFFFFF, and no sysmap_cfg_upd.
REQ-031 Write 0x0C data 32'h0000_0085 -> flg1=5'h05 and locked; a following write to 0x08 -> cfg_err=1 and base1 unchanged; a read of 0x0C -> 32'h00000085.
REQ-032 cfg_req held high for 6 cycles doing reads -> exactly 3 cfg_ack pulses on alternating cycles.
REQ-033 Assert cpurst in the ACK cycle of a write -> no ack, and all outputs return to reset values immediately (asynchronously, without waiting for a clock edge).
